seq_divider_param: RTL and testbench

//  Parametrised multi-cycle restoring divider with an integrated datapath and FSM.

---
 rtl/seq_divider_param.sv | 117 +++++++++++
 tb/tb_seq_divider_param.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider_param.sv
// Multi-cycle restoring divider: one quotient bit per clock, optional signed mode with
// sign-magnitude correction, divide-by-zero and MIN/-1 overflow reporting.
module seq_divider_param #(
  parameter int WIDTH          = 8,
  parameter bit SIGNED_SUPPORT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, q_r, b_r;
  logic [CW-1:0]    cnt;
  logic             sd_r, sv_r, ovf_cand_r;

  logic             s_in, neg_dd, neg_dv;
  logic [WIDTH-1:0] dd_mag, dv_mag;
  logic [WIDTH:0]   t;

  assign s_in   = sgn & SIGNED_SUPPORT;
  assign neg_dd = s_in & dividend[WIDTH-1];
  assign neg_dv = s_in & divisor[WIDTH-1];
  assign dd_mag = neg_dd ? -dividend : dividend;
  assign dv_mag = neg_dv ? -divisor  : divisor;

  // Trial subtraction one bit wider than the operands; the MSB is the borrow.
  assign t = {a_r, q_r[WIDTH-1]} - {1'b0, b_r};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt == CW'(WIDTH-1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      a_r        <= '0;
      q_r        <= '0;
      b_r        <= '0;
      cnt        <= '0;
      sd_r       <= 1'b0;
      sv_r       <= 1'b0;
      ovf_cand_r <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      dbz        <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          ovf        <= 1'b0;
          sd_r       <= neg_dd;
          sv_r       <= neg_dv;
          ovf_cand_r <= s_in & (dividend == MIN) & (divisor == '1);
          if (divisor == '0) begin
            dbz       <= 1'b1;
            quotient  <= '1;
            remainder <= dividend;
          end else begin
            dbz <= 1'b0;
            a_r <= '0;
            q_r <= dd_mag;
            b_r <= dv_mag;
            cnt <= '0;
          end
        end
        CALC: begin
          if (!t[WIDTH]) begin
            a_r <= t[WIDTH-1:0];
            q_r <= {q_r[WIDTH-2:0], 1'b1};
          end else begin
            a_r <= {a_r[WIDTH-2:0], q_r[WIDTH-1]};
            q_r <= {q_r[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          if (ovf_cand_r) begin
            ovf       <= 1'b1;
            quotient  <= MIN;
            remainder <= '0;
          end else begin
            quotient  <= (sd_r ^ sv_r) ? -q_r : q_r;
            remainder <= sd_r ? -a_r : a_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_param.sv
// Directed-vector and random-model bench for seq_divider_param (WIDTH=8, signed support on).
module tb_seq_divider_param;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, sgn;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         busy, done, dbz, ovf;

  int n_chk = 0;
  int n_fail = 0;

  seq_divider_param #(.WIDTH(W), .SIGNED_SUPPORT(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .dbz(dbz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         s;
    logic [W-1:0] dd, dv, q, r;
    logic         z, o;
    int           lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done; sampling on negedges.
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic busy1);
    @(negedge clk);
    start = 1'b1; sgn = s; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = 8'h5A; divisor = 8'h00;
    busy1 = busy;
    lat = 1;
    while (!done && lat <= 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vecs[13];

  initial begin
    int   lat, pulses;
    logic b1;
    logic [W-1:0] eq, er;
    logic ez, eo;

    vecs[0]  = '{1'b0, 8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 10};
    vecs[1]  = '{1'b1, 8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0, 10};
    vecs[2]  = '{1'b1, 8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 10};
    vecs[3]  = '{1'b1, 8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0, 10};
    vecs[4]  = '{1'b0, 8'd37,  8'd0,   8'hFF, 8'h25, 1'b1, 1'b0, 1};
    vecs[5]  = '{1'b1, 8'h85,  8'd0,   8'hFF, 8'h85, 1'b1, 1'b0, 1};
    vecs[6]  = '{1'b1, 8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, 10};
    vecs[7]  = '{1'b0, 8'd255, 8'd1,   8'hFF, 8'h00, 1'b0, 1'b0, 10};
    vecs[8]  = '{1'b0, 8'd200, 8'd7,   8'h1C, 8'h04, 1'b0, 1'b0, 10};
    vecs[9]  = '{1'b0, 8'h80,  8'hFF,  8'h00, 8'h80, 1'b0, 1'b0, 10};
    vecs[10] = '{1'b0, 8'd5,   8'd9,   8'h00, 8'h05, 1'b0, 1'b0, 10};
    vecs[11] = '{1'b1, 8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0, 10};
    vecs[12] = '{1'b1, 8'd7,   8'hFE,  8'hFD, 8'h01, 1'b0, 1'b0, 10};

    rst = 1'b0; start = 1'b0; sgn = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_q", quotient, 0);  chk("rst_r", remainder, 0);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_dbz", dbz, 0);     chk("rst_ovf", ovf, 0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].s, vecs[i].dd, vecs[i].dv, lat, b1);
      chk($sformatf("v%0d_busy", i), b1, 1);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_q", i), quotient, vecs[i].q);
      chk($sformatf("v%0d_r", i), remainder, vecs[i].r);
      chk($sformatf("v%0d_dbz", i), dbz, vecs[i].z);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].o);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done, 0);
      chk($sformatf("v%0d_idle", i), busy, 0);
      chk($sformatf("v%0d_hold_q", i), quotient, vecs[i].q);
    end

    // start pulsed mid-calculation with different operands must be ignored
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk); start = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) begin
        pulses++;
        chk("busy_q", quotient, 8'h0E);
        chk("busy_r", remainder, 8'h02);
      end
      @(negedge clk);
    end
    chk("busy_pulses", pulses, 1);

    // reset in the middle of a division discards everything
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_q", quotient, 0);  chk("mrst_r", remainder, 0);
    chk("mrst_busy", busy, 0);   chk("mrst_done", done, 0);
    rst = 1'b1;
    run_op(1'b0, 8'd9, 8'd3, lat, b1);
    chk("post_rst_lat", lat, 10);
    chk("post_rst_q", quotient, 3);
    chk("post_rst_r", remainder, 0);

    // back-to-back: start held high through DONE begins a new operation
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; dividend = 8'd20; divisor = 8'd6;
    while (!done) @(negedge clk);
    dividend = 8'd21; divisor = 8'd4;
    @(negedge clk);
    chk("b2b_q1", quotient, 3);
    @(negedge clk); start = 1'b0;
    chk("b2b_busy", busy, 1);
    lat = 0;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    chk("b2b_q2", quotient, 5);
    chk("b2b_r2", remainder, 1);
    @(negedge clk);

    // random sweep against a behavioural model
    for (int k = 0; k < 40; k++) begin
      logic s;
      logic [W-1:0] a, b;
      int sa, sb;
      s = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      b = (k % 10 == 0) ? 8'h00 : 8'($urandom);
      ez = 1'b0; eo = 1'b0;
      if (b == 0) begin
        ez = 1'b1; eq = 8'hFF; er = a;
      end else if (s && a == 8'h80 && b == 8'hFF) begin
        eo = 1'b1; eq = 8'h80; er = 8'h00;
      end else if (s) begin
        sa = int'($signed(a)); sb = int'($signed(b));
        eq = 8'(sa / sb); er = 8'(sa % sb);
      end else begin
        eq = a / b; er = a % b;
      end
      run_op(s, a, b, lat, b1);
      chk($sformatf("rnd%0d_q", k), quotient, eq);
      chk($sformatf("rnd%0d_r", k), remainder, er);
      chk($sformatf("rnd%0d_flags", k), {dbz, ovf}, {ez, eo});
      chk($sformatf("rnd%0d_lat", k), lat, ez ? 1 : 10);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
